mlp_hls_deadlock_persist_monitor: RTL and testbench
===================================================

# mlp_hls_deadlock_persist_monitor

Parametrised deadlock monitor for HLS-generated dataflow regions in the MLP accelerator. It watches N_AXIS stream-blocked flags and N_INST sub-instance block/idle pairs. It raises `block` only after a stall condition has persisted for THRESH consecutive cycles. It reports the lowest-index blocking channel and counts block events. It replaces the single-cycle, fixed-width monitor attached to each top-level dataflow instance.

## Interface
- N_AXIS, 2, number of stream-blocked inputs (≥1)
- N_INST, 3, number of monitored sub-instances (≥1)
- THRESH, 16, consecutive stall cycles required before `block` asserts (≥1)
- STICKY, 1, 1: `block` holds until `clear`; 0: `block` drops when the stall disappears
- CNT_W, derived: clog2(THRESH+1), persistence counter width
- SRC_W, derived: max(1, clog2(N_AXIS+N_INST)), source index width

- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- axis_block_sigs  in  N_AXIS  bit i high: stream i blocked this cycle
- inst_idle_sigs  in  N_INST  bit j high: instance j idle
- inst_block_sigs  in  N_INST  bit j high: instance j reports blocked
- clear  in  1  one-cycle pulse; acknowledges and clears a detected block
- block  out  1  registered deadlock flag
- block_src  out  SRC_W  lowest blocking channel index captured at detection; valid while `block`=1
- block_events  out  8  saturating count of entries into BLOCKED

## Operation
- Channel vector (combinational):
  - ch[i] = axis_block_sigs[i] for i < N_AXIS.
  - ch[N_AXIS+j] = inst_block_sigs[j] & ~inst_idle_sigs[j].
  - An idle instance never counts as blocked.
- cand = OR of ch.
- FSM states IDLE, COUNT, BLOCKED. Registered `cnt` has width CNT_W.
- IDLE (cnt=0):
  - If cand and THRESH==1: go to BLOCKED.
  - Else if cand: go to COUNT with cnt=1.
- COUNT:
  - If !cand: go to IDLE with cnt=0.
  - Else if cnt==THRESH-1: go to BLOCKED.
  - Else: cnt+1.
  - The counter never exceeds THRESH-1, so it cannot wrap.
- BLOCKED:
  - STICKY=1: stay until `clear`.
  - STICKY=0: go to IDLE on !cand.
  - cnt holds 0.
- `clear` takes priority over everything in every state. The next state is IDLE with cnt=0, even if cand=1 that cycle. Counting restarts from the following cycle.
- On the IDLE/COUNT→BLOCKED transition:
  - block_src <= index of the lowest set bit of ch in that same cycle.
  - block_events <= min(block_events+1, 255).
- On leaving BLOCKED, block_src <= 0. block_events is cleared only by reset.
- `block` = 1 exactly when the registered state is BLOCKED.

## Timing
- Reset values: block=0, block_src=0, block_events=0, state IDLE, cnt=0.
- Reset is sampled on the clock edge. Reset asserted mid-count or mid-BLOCKED returns all outputs to reset values on the next edge.
- Detection latency: if cand is sampled high on THRESH consecutive edges e0..e0+THRESH-1, `block` is high after edge e0+THRESH-1. With THRESH=1 it is high one cycle after cand, matching the legacy monitor.
- Any single cycle with cand=0 during COUNT restarts the count. A channel switch (different ch bit, cand still 1) does not restart it.
- Release:
  - STICKY=0: `block` falls one cycle after cand is first sampled low.
  - STICKY=1: `block` falls one cycle after `clear`.
- Simultaneous `clear` and detection edge: `clear` wins. No BLOCKED entry and no event increment.
- block_events at 255 stays 255.

## Test plan
- THRESH=4, STICKY=1:
  - Drive axis_block_sigs=2'b01 for 4 cycles → `block` rises after the 4th edge, block_src=0, block_events=1.
  - Pulse `clear` → `block`=0 the next cycle.
- THRESH=4: axis bit 1 high 3 cycles, low 1 cycle, high 3 cycles → `block` never asserts, block_events=0.
- inst_block_sigs=3'b100 with inst_idle_sigs=3'b100 for 20 cycles → no block. Then drop idle[2] → block after 4 cycles, block_src=4.
- STICKY=0, THRESH=2: ch bits 1 and 3 high for 5 cycles, then all low → block_src=1; `block` falls 1 cycle after cand drops.
- `clear` asserted on the cycle cnt==THRESH-1 with cand=1 → no block. Block then asserts THRESH cycles later if cand persists. Reset asserted while BLOCKED → all outputs 0 next cycle.
- 300 detect/clear cycles → block_events saturates at 255.

Source files
------------

// File: rtl/mlp_hls_deadlock_persist_monitor.sv
// Deadlock monitor for HLS dataflow regions: flags a stall only after it persists
// for THRESH consecutive cycles, reports the lowest blocking channel, counts events.
//
// state   | meaning
// IDLE    | no stall candidate seen, cnt = 0
// COUNT   | stall persisting, cnt = consecutive stall cycles so far
// BLOCKED | stall persisted THRESH cycles, block asserted
module mlp_hls_deadlock_persist_monitor #(
    parameter int N_AXIS = 2,
    parameter int N_INST = 3,
    parameter int THRESH = 16,
    parameter int STICKY = 1,
    localparam int CNT_W = $clog2(THRESH + 1),
    localparam int N_CH  = N_AXIS + N_INST,
    localparam int SRC_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [N_AXIS-1:0] i_axis_block_sigs,
    input  logic [N_INST-1:0] i_inst_idle_sigs,
    input  logic [N_INST-1:0] i_inst_block_sigs,
    input  logic              i_clear,
    output logic              o_block,
    output logic [SRC_W-1:0]  o_block_src,
    output logic [7:0]        o_block_events
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COUNT   = 2'd1;
    localparam logic [1:0] S_BLOCKED = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SRC_W-1:0] r_src;
    logic [7:0]       r_events;

    logic [N_CH-1:0]  w_ch;
    logic             w_cand;
    logic [SRC_W-1:0] w_low;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_enter;
    logic             w_leave;

    // An idle instance never counts as blocked.
    assign w_ch   = {i_inst_block_sigs & ~i_inst_idle_sigs, i_axis_block_sigs};
    assign w_cand = |w_ch;

    always_comb begin
        w_low = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_ch[k]) begin
                w_low = SRC_W'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_cand) begin
                        if (THRESH == 1) begin
                            w_state_nxt = S_BLOCKED;
                        end else begin
                            w_state_nxt = S_COUNT;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_COUNT: begin
                    if (!w_cand) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(THRESH - 1)) begin
                        w_state_nxt = S_BLOCKED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_BLOCKED: begin
                    w_cnt_nxt = '0;
                    if ((STICKY == 0) && !w_cand) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign w_enter = (r_state != S_BLOCKED) && (w_state_nxt == S_BLOCKED);
    assign w_leave = (r_state == S_BLOCKED) && (w_state_nxt != S_BLOCKED);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_src    <= '0;
            r_events <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_enter) begin
                r_src <= w_low;
                if (r_events != 8'hFF) begin
                    r_events <= r_events + 8'd1;
                end
            end else if (w_leave) begin
                r_src <= '0;
            end
        end
    end

    assign o_block        = (r_state == S_BLOCKED);
    assign o_block_src    = r_src;
    assign o_block_events = r_events;

endmodule

// File: tb/tb_mlp_hls_deadlock_persist_monitor.sv
// Directed bench: instance A (THRESH=4, sticky) and instance B (THRESH=2, non-sticky)
// share stimulus; each scenario resets both and checks the relevant instance.
module tb_mlp_hls_deadlock_persist_monitor;

    logic       clk;
    logic       rst;
    logic [1:0] axis;
    logic [2:0] idle;
    logic [2:0] iblk;
    logic       clr;

    logic       a_block;
    logic [2:0] a_src;
    logic [7:0] a_events;
    logic       b_block;
    logic [2:0] b_src;
    logic [7:0] b_events;

    int n_chk = 0;
    int n_err = 0;

    mlp_hls_deadlock_persist_monitor #(
        .N_AXIS(2), .N_INST(3), .THRESH(4), .STICKY(1)
    ) dut_a (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_axis_block_sigs(axis),
        .i_inst_idle_sigs (idle),
        .i_inst_block_sigs(iblk),
        .i_clear          (clr),
        .o_block          (a_block),
        .o_block_src      (a_src),
        .o_block_events   (a_events)
    );

    mlp_hls_deadlock_persist_monitor #(
        .N_AXIS(2), .N_INST(3), .THRESH(2), .STICKY(0)
    ) dut_b (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_axis_block_sigs(axis),
        .i_inst_idle_sigs (idle),
        .i_inst_block_sigs(iblk),
        .i_clear          (clr),
        .o_block          (b_block),
        .o_block_src      (b_src),
        .o_block_events   (b_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        axis = '0;
        idle = '0;
        iblk = '0;
        clr  = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        axis = '0;
        idle = '0;
        iblk = '0;
        clr  = 1'b0;
        #2;

        // reset values and basic sticky detection
        do_reset();
        chk("rst_block", a_block, 0);
        chk("rst_src", a_src, 0);
        chk("rst_events", a_events, 0);
        axis = 2'b01;
        tick(3);
        chk("det_early", a_block, 0);
        tick(1);
        chk("det_block", a_block, 1);
        chk("det_src", a_src, 0);
        chk("det_events", a_events, 1);
        axis = 2'b00;
        tick(2);
        chk("sticky_hold", a_block, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_block", a_block, 0);
        chk("clr_src", a_src, 0);
        chk("clr_events_kept", a_events, 1);

        // a single gap restarts the count; channel switch does not
        do_reset();
        axis = 2'b10;
        tick(3);
        axis = 2'b00;
        tick(1);
        axis = 2'b10;
        tick(3);
        chk("gap_block", a_block, 0);
        chk("gap_events", a_events, 0);
        axis = 2'b01;
        tick(1);
        chk("switch_block", a_block, 1);
        chk("switch_src", a_src, 0);

        // idle instance masks its block flag
        do_reset();
        iblk = 3'b100;
        idle = 3'b100;
        tick(20);
        chk("idle_mask", a_block, 0);
        idle = 3'b000;
        tick(3);
        chk("inst_early", a_block, 0);
        tick(1);
        chk("inst_block", a_block, 1);
        chk("inst_src", a_src, 4);

        // non-sticky, THRESH=2, channels 1 and 3
        do_reset();
        axis = 2'b10;
        iblk = 3'b010;
        tick(1);
        chk("ns_early", b_block, 0);
        tick(1);
        chk("ns_block", b_block, 1);
        chk("ns_src", b_src, 1);
        tick(3);
        chk("ns_hold", b_block, 1);
        axis = 2'b00;
        iblk = 3'b000;
        tick(1);
        chk("ns_release", b_block, 0);
        chk("ns_src_zero", b_src, 0);
        chk("ns_events", b_events, 1);

        // clear on the detection edge wins
        do_reset();
        axis = 2'b01;
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clrwin_block", a_block, 0);
        chk("clrwin_events", a_events, 0);
        tick(3);
        chk("clrwin_early", a_block, 0);
        tick(1);
        chk("clrwin_later", a_block, 1);
        chk("clrwin_events2", a_events, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstblk_block", a_block, 0);
        chk("rstblk_src", a_src, 0);
        chk("rstblk_events", a_events, 0);

        // event counter saturation
        do_reset();
        for (int i = 0; i < 254; i++) begin
            axis = 2'b01;
            tick(4);
            clr = 1'b1;
            axis = 2'b00;
            tick(1);
            clr = 1'b0;
        end
        chk("sat_254", a_events, 254);
        for (int i = 0; i < 46; i++) begin
            axis = 2'b01;
            tick(4);
            clr = 1'b1;
            axis = 2'b00;
            tick(1);
            clr = 1'b0;
        end
        chk("sat_255", a_events, 255);
        axis = 2'b01;
        tick(4);
        chk("sat_block", a_block, 1);
        chk("sat_hold", a_events, 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
